// File: rtl/serial_frame_tx_pkg.sv
// Shared definitions for the serial frame transmitter: FSM state codes and
// idle line levels. The parity-bit states (PAR_LO/PAR_HI) keep their codes
// even when the parity option is compiled out.
package serial_frame_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    START_A = 4'd1,
    START_B = 4'd2,
    BIT_LO  = 4'd3,
    BIT_HI  = 4'd4,
    PAR_LO  = 4'd5,
    PAR_HI  = 4'd6,
    STOP_A  = 4'd7,
    STOP_B  = 4'd8,
    STOP_C  = 4'd9
  } state_t;

  localparam logic SDA_IDLE = 1'b1;
  localparam logic SCL_IDLE = 1'b1;

endpackage

// File: rtl/serial_frame_tx_if.sv
// Word handshake plus the two-wire line of the serial frame transmitter.
// Handshake: the source holds data_in and raises valid; the transmitter
// pulses ack for exactly the cycle in which it captures data_in. data_in
// only has to be stable in that ack cycle, and valid is only looked at in
// IDLE and in the word-boundary cycle.
interface serial_frame_tx_if #(
  parameter int DATA_W = 4
);
  logic [DATA_W-1:0] data_in;
  logic              valid;
  logic              ack;
  logic              sda;
  logic              scl;

  // Word source side: supplies words, watches ack and the line.
  modport master (output data_in, output valid, input ack, input sda, input scl);
  // Transmitter side: consumes words, drives ack and the line.
  modport slave  (input data_in, input valid, output ack, output sda, output scl);
endinterface

// File: rtl/serial_frame_tx_timer.sv
// Phase timer: phase_done marks the last sclk cycle of a HALF_PER-long line
// phase. The count wraps to zero on phase_done, so every state entered on a
// phase_done starts a fresh phase; restart holds it at zero while idle.
module serial_phase_timer #(
  parameter int HALF_PER = 2
) (
  input  logic sclk,
  input  logic rst,
  input  logic restart,
  input  logic enable,
  output logic phase_done
);

  localparam int CW = $clog2(HALF_PER + 1);
  localparam logic [CW-1:0] LAST = CW'(HALF_PER - 1);

  logic [CW-1:0] cnt;

  // Count sclk cycles within the current phase, wrapping at the phase end.
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign phase_done = enable && (cnt == LAST);

endmodule

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: parallel-to-serial two-wire transmitter.
// Frame = start condition, one or more DATA_W-bit words MSB first (up to
// MAX_BURST words without an intervening stop/start), stop condition.
// Every non-idle state lasts HALF_PER sclk cycles. sda/scl are registered.
// Option macro SERIAL_FRAME_TX_PARITY_EN: appends an even-parity bit
// (PAR_LO/PAR_HI) after each word; the word boundary then follows PAR_HI.
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int HALF_PER  = 2,
  parameter int MAX_BURST = 1
) (
  input  logic                         sclk,
  input  logic                         rst,
  serial_frame_tx_if.slave             bus,
  output logic                         busy,
  output logic [3:0]                   state,
  output logic [$clog2(MAX_BURST):0]   word_cnt
);

  localparam int BCW = $clog2(DATA_W) + 1;
  localparam int WCW = $clog2(MAX_BURST) + 1;
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_W - 1);
  localparam logic [WCW-1:0] BURST_MAX = WCW'(MAX_BURST);

  state_t            state_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_next;
  logic [BCW-1:0]    bit_cnt_q;
  logic [WCW-1:0]    word_cnt_q;
  logic              sda_q;
  logic              scl_q;
  logic              phase_done;
  logic              last_bit;
  logic              at_boundary;
  logic              take_next;
  logic              accept_idle;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic              par_q;
`endif

  serial_phase_timer #(.HALF_PER(HALF_PER)) u_timer (
    .sclk       (sclk),
    .rst        (rst),
    .restart    (state_q == IDLE),
    .enable     (state_q != IDLE),
    .phase_done (phase_done)
  );

  assign shift_next = shift_q << 1;
  assign last_bit   = (bit_cnt_q == LAST_BIT);

  // The word boundary is the final cycle of the last line phase of a word.
`ifdef SERIAL_FRAME_TX_PARITY_EN
  assign at_boundary = phase_done && (state_q == PAR_HI);
`else
  assign at_boundary = phase_done && (state_q == BIT_HI) && last_bit;
`endif

  assign take_next   = at_boundary && (word_cnt_q < BURST_MAX) && bus.valid;
  assign accept_idle = (state_q == IDLE) && bus.valid;

  // ack is gated by rst so no capture is ever acknowledged while in reset.
  assign bus.ack  = rst && (accept_idle || take_next);
  assign bus.sda  = sda_q;
  assign bus.scl  = scl_q;
  assign busy     = (state_q != IDLE);
  assign state    = state_q;
  assign word_cnt = word_cnt_q;

  // Frame sequencer: state, line levels, shift register and counters.
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      sda_q      <= SDA_IDLE;
      scl_q      <= SCL_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else if (at_boundary) begin
      if (take_next) begin
        // Chain the next word straight into its first low phase.
        shift_q    <= bus.data_in;
        sda_q      <= bus.data_in[DATA_W-1];
        scl_q      <= 1'b0;
        bit_cnt_q  <= '0;
        word_cnt_q <= word_cnt_q + WCW'(1);
`ifdef SERIAL_FRAME_TX_PARITY_EN
        par_q      <= ^bus.data_in;
`endif
        state_q    <= BIT_LO;
      end else begin
        sda_q   <= 1'b0;
        scl_q   <= 1'b0;
        state_q <= STOP_A;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.valid) begin
            shift_q    <= bus.data_in;
            bit_cnt_q  <= '0;
            word_cnt_q <= WCW'(1);
`ifdef SERIAL_FRAME_TX_PARITY_EN
            par_q      <= ^bus.data_in;
`endif
            sda_q      <= 1'b0;
            scl_q      <= 1'b1;
            state_q    <= START_A;
          end
        end
        START_A: begin
          if (phase_done) begin
            scl_q   <= 1'b0;
            state_q <= START_B;
          end
        end
        START_B: begin
          if (phase_done) begin
            sda_q   <= shift_q[DATA_W-1];
            state_q <= BIT_LO;
          end
        end
        BIT_LO: begin
          if (phase_done) begin
            scl_q   <= 1'b1;
            state_q <= BIT_HI;
          end
        end
        BIT_HI: begin
          if (phase_done && !last_bit) begin
            shift_q   <= shift_next;
            sda_q     <= shift_next[DATA_W-1];
            scl_q     <= 1'b0;
            bit_cnt_q <= bit_cnt_q + BCW'(1);
            state_q   <= BIT_LO;
          end
`ifdef SERIAL_FRAME_TX_PARITY_EN
          else if (phase_done) begin
            sda_q   <= par_q;
            scl_q   <= 1'b0;
            state_q <= PAR_LO;
          end
`endif
        end
`ifdef SERIAL_FRAME_TX_PARITY_EN
        PAR_LO: begin
          if (phase_done) begin
            scl_q   <= 1'b1;
            state_q <= PAR_HI;
          end
        end
`endif
        STOP_A: begin
          if (phase_done) begin
            scl_q   <= 1'b1;
            state_q <= STOP_B;
          end
        end
        STOP_B: begin
          if (phase_done) begin
            sda_q   <= 1'b1;
            state_q <= STOP_C;
          end
        end
        STOP_C: begin
          if (phase_done) begin
            word_cnt_q <= '0;
            state_q    <= IDLE;
          end
        end
        default: begin
          sda_q      <= SDA_IDLE;
          scl_q      <= SCL_IDLE;
          word_cnt_q <= '0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

endmodule
